// File: rtl/tc_mma_scheduler.sv
// Round-robin scheduler sharing one FP16 MMA tensor core tile among NUM_REQ warp slots.
// One single-cycle issue per grant, owner index held until result/timeout, sticky stray-result flag.
module tc_mma_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int SEL_W       = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_mask,
    output logic [NUM_REQ-1:0] req_ack,
    output logic [NUM_REQ-1:0] req_done,
    output logic [NUM_REQ-1:0] req_err,
    output logic               tc_mma_valid,
    output logic               tc_mma_enable,
    input  logic               tc_mma_ready,
    input  logic               tc_result_valid,
    output logic [SEL_W-1:0]   tc_sel,
    output logic               busy,
    output logic               stray_err,
    output logic [CNT_W-1:0]   jobs_issued
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [TMR_W-1:0]   r_timer;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;
    logic               r_mma_valid;
    logic               r_busy;
    logic               r_stray;
    logic [CNT_W-1:0]   r_jobs;

    state_t             w_nxt_state;
    logic [SEL_W-1:0]   w_nxt_rr;
    logic [SEL_W-1:0]   w_nxt_sel;
    logic [TMR_W-1:0]   w_nxt_timer;
    logic [NUM_REQ-1:0] w_nxt_ack;
    logic [NUM_REQ-1:0] w_nxt_done;
    logic [NUM_REQ-1:0] w_nxt_err;
    logic [CNT_W-1:0]   w_nxt_jobs;
    logic               w_nxt_valid;
    logic               w_nxt_busy;

    logic [NUM_REQ-1:0]   w_elig;
    logic [2*NUM_REQ-1:0] w_rot;
    logic                 w_found;
    logic [SEL_W-1:0]     w_winner;
    logic [TMR_W-1:0]     w_tmr_inc;
    logic [SEL_W-1:0]     w_sel_succ;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    assign w_elig     = req & req_mask;
    assign w_tmr_inc  = r_timer + TMR_W'(1);
    assign w_sel_succ = (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);

    // Rotate eligibility so bit 0 is rr_ptr; first set bit wins, mapped back with wrap.
    always_comb begin
        w_rot    = {w_elig, w_elig} >> r_rr_ptr;
        w_found  = 1'b0;
        w_winner = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found  = 1'b1;
                w_winner = (int'(r_rr_ptr) + j >= NUM_REQ) ? SEL_W'(int'(r_rr_ptr) + j - NUM_REQ)
                                                           : SEL_W'(int'(r_rr_ptr) + j);
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_rr    = r_rr_ptr;
        w_nxt_sel   = r_sel;
        w_nxt_timer = r_timer;
        w_nxt_ack   = '0;
        w_nxt_done  = '0;
        w_nxt_err   = '0;
        w_nxt_jobs  = r_jobs;
        case (r_state)
            S_IDLE: begin
                if (w_found && tc_mma_ready) begin
                    w_nxt_state = S_ISSUE;
                    w_nxt_sel   = w_winner;
                    w_nxt_ack   = onehot(w_winner);
                end
            end
            S_ISSUE: begin
                w_nxt_state = S_WAIT;
                w_nxt_jobs  = r_jobs + CNT_W'(1);
                w_nxt_timer = '0;
            end
            S_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (tc_result_valid) begin
                    w_nxt_state = S_DONE;
                    w_nxt_done  = onehot(r_sel);
                end else if (w_tmr_inc == TMR_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_err   = onehot(r_sel);
                    w_nxt_rr    = w_sel_succ;
                end else begin
                    w_nxt_timer = w_tmr_inc;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
                w_nxt_rr    = w_sel_succ;
            end
            default: w_nxt_state = S_IDLE;
        endcase
        w_nxt_valid = (w_nxt_state == S_ISSUE);
        w_nxt_busy  = (w_nxt_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_sel       <= '0;
            r_timer     <= '0;
            r_ack       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_mma_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_stray     <= 1'b0;
            r_jobs      <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_rr_ptr    <= w_nxt_rr;
            r_sel       <= w_nxt_sel;
            r_timer     <= w_nxt_timer;
            r_ack       <= w_nxt_ack;
            r_done      <= w_nxt_done;
            r_err       <= w_nxt_err;
            r_mma_valid <= w_nxt_valid;
            r_busy      <= w_nxt_busy;
            r_jobs      <= w_nxt_jobs;
            if (tc_result_valid && r_state != S_WAIT)
                r_stray <= 1'b1;
        end
    end

    assign req_ack       = r_ack;
    assign req_done      = r_done;
    assign req_err       = r_err;
    assign tc_mma_valid  = r_mma_valid;
    assign tc_mma_enable = r_mma_valid;
    assign tc_sel        = r_sel;
    assign busy          = r_busy;
    assign stray_err     = r_stray;
    assign jobs_issued   = r_jobs;

endmodule

// File: tb/tb_tc_mma_scheduler.sv
// Bench for tc_mma_scheduler: K=4 core model, scoreboard queues of expected grant/done/err owners.
module tb_tc_mma_scheduler;
    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] req_mask = '0;
    logic [N-1:0] req_ack, req_done, req_err;
    logic         tc_mma_valid, tc_mma_enable;
    logic         tc_mma_ready = 1'b0;
    logic         tc_result_valid;
    logic [1:0]   tc_sel;
    logic         busy, stray_err;
    logic [15:0]  jobs_issued;

    logic [5:0]   core_pipe = '0;
    logic         core_rv = 1'b0;
    logic         core_stall = 1'b0;
    logic         stray_inj = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int exp_q[$];
    int done_q[$];
    int err_q[$];

    tc_mma_scheduler #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mask(req_mask),
        .req_ack(req_ack), .req_done(req_done), .req_err(req_err),
        .tc_mma_valid(tc_mma_valid), .tc_mma_enable(tc_mma_enable),
        .tc_mma_ready(tc_mma_ready), .tc_result_valid(tc_result_valid),
        .tc_sel(tc_sel), .busy(busy), .stray_err(stray_err), .jobs_issued(jobs_issued)
    );

    always #5 clk = ~clk;

    // Core with K=4: issue in cycle t, result_valid during cycle t+6.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_pipe <= '0;
            core_rv   <= 1'b0;
        end else begin
            core_pipe <= {core_pipe[4:0], tc_mma_valid};
            core_rv   <= core_pipe[5] & ~core_stall;
        end
    end
    assign tc_result_valid = core_rv | stray_inj;

    function automatic logic [N-1:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; req = '0; req_mask = 4'hF; tc_mma_ready = 1'b1;
        core_stall = 1'b0; stray_inj = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_q.delete(); done_q.delete(); err_q.delete();
    endtask

    task automatic wait_ack(input int bound, output int cyc);
        cyc = -1;
        for (int c = 1; c <= bound && cyc < 0; c++) begin
            @(negedge clk);
            if (req_ack !== '0) cyc = c;
        end
    endtask

    task automatic wait_idle(input int bound, output int cyc);
        cyc = -1;
        for (int c = 1; c <= bound && cyc < 0; c++) begin
            @(negedge clk);
            if (busy === 1'b0) cyc = c;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ack, req_done, req_err} !== '0) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 0", {req_ack, req_done, req_err});
        end
        n_checks++;
        if ({tc_mma_valid, tc_mma_enable, busy, stray_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {tc_mma_valid, tc_mma_enable, busy, stray_err});
        end
        n_checks++;
        if (tc_sel !== 2'd0 || jobs_issued !== 16'd0) begin
            n_fail++; $display("FAIL reset_sel_jobs: got sel=%0d jobs=%0d want 0 0", tc_sel, jobs_issued);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int e, done_at, vcnt, selbad;
        req_mask = 4'hF; tc_mma_ready = 1'b1;
        exp_q.push_back(0); done_q.push_back(0);
        req = 4'b0001;
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (req_ack !== oh(e) || tc_sel !== 2'(e)) begin
            n_fail++; $display("FAIL single_ack: got ack=%b sel=%0d want ack=%b sel=%0d", req_ack, tc_sel, oh(e), e);
        end
        n_checks++;
        if (tc_mma_valid !== 1'b1 || tc_mma_enable !== 1'b1) begin
            n_fail++; $display("FAIL single_issue: got valid=%b en=%b want 1 1", tc_mma_valid, tc_mma_enable);
        end
        req = '0;
        done_at = -1; vcnt = 0; selbad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (tc_mma_valid !== 1'b0) vcnt++;
            if (tc_sel !== 2'd0) selbad++;
            if (req_done !== '0 && done_at < 0) begin
                done_at = k;
                e = (done_q.size() > 0) ? done_q.pop_front() : -1;
                n_checks++;
                if (req_done !== oh(e)) begin
                    n_fail++; $display("FAIL single_done_owner: got %b want %b", req_done, oh(e));
                end
            end
        end
        n_checks++;
        if (done_at !== 7) begin
            n_fail++; $display("FAIL single_done_latency: got %0d want 7", done_at);
        end
        n_checks++;
        if (vcnt !== 0 || selbad !== 0) begin
            n_fail++; $display("FAIL single_valid_width_sel: got extra_valid=%0d sel_changes=%0d want 0 0", vcnt, selbad);
        end
        n_checks++;
        if (jobs_issued !== 16'd1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_jobs: got jobs=%0d busy=%b want 1 0", jobs_issued, busy);
        end
    endtask

    task automatic test_round_robin();
        int e, acks, dones, ohbad, overlap;
        logic prev_busy;
        do_reset();
        foreach (exp_q[i]) exp_q.delete(i);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(i % N); done_q.push_back(i % N);
        end
        req = 4'hF;
        acks = 0; dones = 0; ohbad = 0; overlap = 0; prev_busy = 1'b0;
        for (int c = 0; c < 120 && dones < 5; c++) begin
            @(negedge clk);
            if (tc_mma_valid === 1'b1 && prev_busy === 1'b1) overlap++;
            prev_busy = busy;
            if (req_ack !== '0) begin
                acks++;
                if (!$onehot(req_ack)) ohbad++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_checks++;
                if (req_ack !== oh(e) || tc_sel !== 2'(e)) begin
                    n_fail++; $display("FAIL rr_grant%0d: got ack=%b sel=%0d want %b", acks, req_ack, tc_sel, oh(e));
                end
                if (acks == 5) req = '0;
            end
            if (req_done !== '0) begin
                dones++;
                e = (done_q.size() > 0) ? done_q.pop_front() : -1;
                n_checks++;
                if (req_done !== oh(e)) begin
                    n_fail++; $display("FAIL rr_done%0d: got %b want %b", dones, req_done, oh(e));
                end
            end
        end
        n_checks++;
        if (acks !== 5 || dones !== 5 || ohbad !== 0 || overlap !== 0) begin
            n_fail++; $display("FAIL rr_counts: got acks=%0d dones=%0d non_onehot=%0d overlap=%0d want 5 5 0 0", acks, dones, ohbad, overlap);
        end
        @(negedge clk);
        n_checks++;
        if (jobs_issued !== 16'd5) begin
            n_fail++; $display("FAIL rr_jobs: got %0d want 5", jobs_issued);
        end
    endtask

    task automatic test_mask();
        int e, acks, ack3;
        do_reset();
        req_mask = 4'b0010;
        exp_q.push_back(1);
        req = 4'b1010;
        acks = 0; ack3 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ack[3] === 1'b1) ack3++;
            if (req_ack !== '0) begin
                acks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_checks++;
                if (req_ack !== oh(e)) begin
                    n_fail++; $display("FAIL mask_grant: got %b want %b", req_ack, oh(e));
                end
                req = 4'b1000;
            end
        end
        n_checks++;
        if (acks !== 1 || ack3 !== 0) begin
            n_fail++; $display("FAIL mask_only_r1: got acks=%0d ack3=%0d want 1 0", acks, ack3);
        end
        req = '0;
    endtask

    task automatic test_ready_block();
        int e, bad, got, idle;
        do_reset();
        tc_mma_ready = 1'b0;
        exp_q.push_back(0);
        req = 4'b0001;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_ack !== '0 || tc_mma_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ready_block: got grants_while_not_ready=%0d busy=%b want 0 0", bad, busy);
        end
        tc_mma_ready = 1'b1;
        wait_ack(2, got);
        n_checks++;
        if (got < 0) begin
            n_fail++; $display("FAIL ready_grant: got no ack within 2 cycles want ack");
        end else begin
            e = exp_q.pop_front();
            if (req_ack !== oh(e)) begin
                n_fail++; $display("FAIL ready_grant: got %b want %b", req_ack, oh(e));
            end
        end
        req = '0;
        wait_idle(15, idle);
        n_checks++;
        if (idle < 0) begin
            n_fail++; $display("FAIL ready_job_end: got busy stuck want idle within 15");
        end
    endtask

    task automatic test_timeout();
        int e, got, err_n, err1_at, err2_at, ack2_at, dones;
        do_reset();
        core_stall = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1);
        err_q.push_back(0); err_q.push_back(1);
        req = 4'b0011;
        wait_ack(3, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got < 0 || req_ack !== oh(e)) begin
            n_fail++; $display("FAIL to_first_grant: got %b want %b", req_ack, oh(e));
        end
        req = 4'b0010;
        err_n = 0; err1_at = -1; err2_at = -1; ack2_at = -1; dones = 0;
        for (int k = 1; k <= 40 && err_n < 2; k++) begin
            @(negedge clk);
            if (req_done !== '0) dones++;
            if (req_ack !== '0 && ack2_at < 0) begin
                ack2_at = k;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_checks++;
                if (req_ack !== oh(e)) begin
                    n_fail++; $display("FAIL to_next_grant: got %b want %b", req_ack, oh(e));
                end
                req = '0;
            end
            if (req_err !== '0) begin
                err_n++;
                if (err_n == 1) err1_at = k; else err2_at = k;
                e = (err_q.size() > 0) ? err_q.pop_front() : -1;
                n_checks++;
                if (req_err !== oh(e)) begin
                    n_fail++; $display("FAIL to_err%0d_owner: got %b want %b", err_n, req_err, oh(e));
                end
            end
        end
        n_checks++;
        if (err1_at !== 16 || ack2_at !== 17 || err2_at !== 33) begin
            n_fail++; $display("FAIL to_timing: got err1=%0d ack2=%0d err2=%0d want 16 17 33", err1_at, ack2_at, err2_at);
        end
        n_checks++;
        if (dones !== 0 || jobs_issued !== 16'd2) begin
            n_fail++; $display("FAIL to_no_done: got dones=%0d jobs=%0d want 0 2", dones, jobs_issued);
        end
        n_checks++;
        if (stray_err !== 1'b0) begin
            n_fail++; $display("FAIL stray_pre: got %b want 0", stray_err);
        end
        core_stall = 1'b0;
        stray_inj = 1'b1;
        @(negedge clk);
        stray_inj = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (stray_err !== 1'b1 || req_done !== '0) begin
            n_fail++; $display("FAIL stray_sticky: got stray=%b done=%b want 1 0000", stray_err, req_done);
        end
    endtask

    task automatic test_timeout_edge();
        int got, early;
        do_reset();
        core_stall = 1'b1;
        req = 4'b0001;
        wait_ack(3, got);
        req = '0;
        early = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (req_done !== '0 || req_err !== '0) early++;
        end
        stray_inj = 1'b1;
        @(negedge clk);
        stray_inj = 1'b0;
        n_checks++;
        if (got < 0 || early !== 0 || req_done !== 4'b0001 || req_err !== '0) begin
            n_fail++; $display("FAIL to_edge_done: got ack_at=%0d early=%0d done=%b err=%b want done=0001 err=0000", got, early, req_done, req_err);
        end
        @(negedge clk);
        n_checks++;
        if (req_err !== '0 || stray_err !== 1'b0) begin
            n_fail++; $display("FAIL to_edge_no_err: got err=%b stray=%b want 0000 0", req_err, stray_err);
        end
        core_stall = 1'b0;
    endtask

    task automatic test_reset_midjob();
        int e, got, idle, dones, errs;
        logic [N-1:0] done_seen;
        do_reset();
        req = 4'b0100;
        wait_ack(3, got);
        req = '0;
        wait_idle(15, idle);
        req = 4'b1000;
        wait_ack(3, got);
        req = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || jobs_issued !== 16'd2) begin
            n_fail++; $display("FAIL midjob_setup: got busy=%b jobs=%0d want 1 2", busy, jobs_issued);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ack, req_done, req_err, tc_mma_valid, tc_mma_enable, tc_sel, busy, stray_err, jobs_issued} !== '0) begin
            n_fail++; $display("FAIL midjob_async_reset: got ack=%b done=%b err=%b v=%b sel=%0d busy=%b jobs=%0d want all 0",
                               req_ack, req_done, req_err, tc_mma_valid, tc_sel, busy, jobs_issued);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(1); exp_q.push_back(2);
        @(negedge clk);
        req = 4'b1010;
        wait_ack(3, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got < 0 || req_ack !== oh(e) || tc_sel !== 2'(e)) begin
            n_fail++; $display("FAIL midjob_rr_restart: got ack=%b sel=%0d want %b sel=%0d", req_ack, tc_sel, oh(e), e);
        end
        req = '0;
        dones = 0; errs = 0; done_seen = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (req_done !== '0) begin dones++; done_seen = req_done; end
            if (req_err !== '0) errs++;
        end
        n_checks++;
        if (dones !== 1 || done_seen !== 4'b0010 || errs !== 0 || stray_err !== 1'b0) begin
            n_fail++; $display("FAIL midjob_abandon: got dones=%0d last=%b errs=%0d stray=%b want 1 0010 0 0", dones, done_seen, errs, stray_err);
        end
        req = 4'b0100;
        wait_ack(3, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got < 0 || req_ack !== oh(e) || tc_sel !== 2'(e)) begin
            n_fail++; $display("FAIL midjob_sel2: got ack=%b sel=%0d want %b sel=%0d", req_ack, tc_sel, oh(e), e);
        end
        req = '0;
        wait_idle(15, idle);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_ready_block();
        test_timeout();
        test_timeout_edge();
        test_reset_midjob();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tc_mma_scheduler.md
Name: tc_mma_scheduler

Overview:
Shares one FP16 MMA tensor core tile among NUM_REQ requesters (warp slots) using round-robin arbitration. Issues exactly one single-cycle mma_valid/mma_enable pulse per granted job and holds the operand-select index stable until the job's result returns. Routes result_valid back to the owning requester as a done pulse. Watchdog-protects each job against a missing result and counts issued jobs.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
SEL_W, $clog2(NUM_REQ), width of select/owner index
TIMEOUT_CYC, 64, max WAIT cycles before a job is aborted (must exceed core K+2)
CNT_W, 16, width of issued-job counter

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester job request, level
req_mask  in  NUM_REQ  1 = requester eligible; masked requests ignored
req_ack  out  NUM_REQ  one-hot 1-cycle pulse: job accepted by core
req_done  out  NUM_REQ  one-hot 1-cycle pulse: result available on core matrix_d
req_err  out  NUM_REQ  one-hot 1-cycle pulse: job timed out, no result
tc_mma_valid  out  1  to core mma_valid
tc_mma_enable  out  1  to core mma_enable
tc_mma_ready  in  1  from core mma_ready
tc_result_valid  in  1  from core result_valid
tc_sel  out  SEL_W  owner index; drives external A/B/C operand mux and D demux
busy  out  1  job in flight (ISSUE, WAIT or DONE)
stray_err  out  1  sticky: tc_result_valid seen outside WAIT
jobs_issued  out  CNT_W  count of ISSUE cycles, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, all outputs 0 (tc_sel=0, jobs_issued=0, stray_err=0), timeout counter 0. Reset mid-job abandons the job with no done/err pulse.
- All outputs registered; no combinational in-to-out paths.
- eligible = req & req_mask.
- IDLE: if eligible!=0 and tc_mma_ready=1, select the first set bit of eligible scanning from rr_ptr upward with wrap; register tc_sel=winner; next state=ISSUE. Otherwise stay in IDLE. tc_mma_ready=0 blocks the grant.
- ISSUE (exactly 1 cycle): tc_mma_valid=tc_mma_enable=1, req_ack[tc_sel]=1, jobs_issued+=1 (wrap modulo 2^CNT_W), timer cleared; next state=WAIT. Operands must be valid at the external mux in this cycle. The requester deasserts req after the ack; a req still high after ack is treated as a new job.
- WAIT: tc_mma_valid=tc_mma_enable=0. On tc_result_valid=1 go to DONE. Otherwise timer+=1; at timer==TIMEOUT_CYC-1, pulse req_err[tc_sel] next cycle and return to IDLE with rr_ptr=(tc_sel+1) mod NUM_REQ.
- DONE (1 cycle): req_done[tc_sel]=1; rr_ptr=(tc_sel+1) mod NUM_REQ; next state=IDLE. matrix_d is valid from this cycle until the next job's writeback.
- tc_sel is constant from ISSUE through DONE/err; it is not changed in IDLE until a new grant.
- With core K=4: ISSUE at cycle t; core MAC t+1..t+4; WRITEBACK t+5; tc_result_valid at t+6; req_done at t+7. Earliest next ISSUE is t+9 (IDLE at t+8 sees ready).
- tc_result_valid in IDLE/ISSUE/DONE: ignored for routing; stray_err set to 1 and held until reset.
- A request withdrawn or masked before grant is dropped silently. Changing req_mask during WAIT does not affect the in-flight job.
- A job whose result and timeout fall in the same cycle completes normally (DONE), with no err pulse.
- busy = state!=IDLE, registered together with the state.

Test Plan:
- Single req: req=0001, mask=1111, ready=1, core K=4 -> ack[0] 1 cycle after req, tc_mma_valid 1 cycle wide, done[0] 7 cycles after ack, jobs_issued=1, tc_sel=0 throughout.
- All four requesting continuously -> grant order 0,1,2,3,0; each ack one-hot; no overlap of ISSUE with WAIT; jobs_issued=5.
- req=1010, mask=0010 -> only requester 1 served; requester 3 never acked.
- tc_mma_ready held 0 with req=0001 for 10 cycles -> no ack and no tc_mma_valid; grant within 2 cycles after ready rises.
- Core stalled (no result_valid), TIMEOUT_CYC=16 -> err[sel] pulse 16 cycles after ISSUE, no done, next requester served; a later stray result_valid sets stray_err=1.
- rst_n asserted in WAIT -> all outputs 0 immediately; after release, req=0100 served with tc_sel=2 and rr_ptr starting from 0.
